// File: rtl/cpu_dev_pkg.sv
// Shared definitions for devices on the processor system bus: register offsets,
// CTRL field positions, mode codes, timer FSM encoding and the byte-lane merge helper.
package cpu_dev_pkg;

    localparam logic [1:0] CTRL_A   = 2'd0;
    localparam logic [1:0] PRESET_A = 2'd1;
    localparam logic [1:0] COUNT_A  = 2'd2;

    localparam int EN_B     = 0;
    localparam int MODE_LSB = 1;
    localparam int IM_B     = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// 32-bit down-counting bus timer with one-shot and auto-reload modes.
// Registers CTRL/PRESET/COUNT; irq is the pending flag gated by the CTRL mask.
//
// state | meaning
// IDLE  | waiting for EN
// LOAD  | COUNT takes PRESET
// CNT   | decrementing while EN, frozen while !EN
// INT   | expiry: one-shot drops EN, auto-reload reloads
module timer_dev
    import cpu_dev_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    timer_state_e state_q, state_d;
    logic [3:0]   ctrl_q, ctrl_d;
    logic [31:0]  preset_q, preset_d;
    logic [31:0]  count_q, count_d;
    logic         pend_q, pend_d;

    logic ctrl_wr, preset_wr, en, reload;

    assign ctrl_wr   = we && (addr == CTRL_A);
    assign preset_wr = we && (addr == PRESET_A);
    assign en        = ctrl_q[EN_B];
    assign reload    = (ctrl_q[MODE_LSB +: 2] == MODE_RELOAD);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        case (state_q)
            ST_IDLE: if (en) state_d = ST_LOAD;
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (en) begin
                    if (count_q != 32'd0) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        state_d = ST_INT;
                        pend_d  = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (reload) begin
                    state_d = ST_LOAD;
                    pend_d  = 1'b0;
                end else begin
                    ctrl_d[EN_B] = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (preset_wr) preset_d = be_merge(preset_q, wd, be);

        // Applied last so software beats the expiry EN clear and the pending set;
        // an all-lanes-off CTRL write still acknowledges the interrupt.
        if (ctrl_wr) begin
            if (be[0]) ctrl_d = wd[3:0];
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        case (addr)
            CTRL_A:   rd = {28'd0, ctrl_q};
            PRESET_A: rd = preset_q;
            COUNT_A:  rd = count_q;
            default:  rd = 32'd0;
        endcase
    end

    assign irq = pend_q & ctrl_q[IM_B];

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: per-feature tasks with an expected-value queue.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [1:0] A_CTRL = 2'd0, A_PRESET = 2'd1, A_COUNT = 2'd2, A_RSVD = 2'd3;

    always #5 clk = ~clk;

    timer_dev dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we),
        .be(be), .wd(wd), .rd(rd), .irq(irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wd = d; be = b; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rd;
    endtask

    task automatic do_reset();
        we = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v, e;
        reset = 1'b0;
        addr = A_PRESET; wd = 32'hFFFF_FFFF; be = 4'hF; we = 1'b1;
        tick();
        addr = A_CTRL;
        tick();
        we = 1'b0;
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(32'd0);
            rdreg(2'(a), v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, v, e);
            end
        end
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        checks++;
        if ({31'd0, irq} !== e) begin
            errors++;
            $display("FAIL reset_irq: got %b expected %0d", irq, e);
        end
        reset = 1'b1;
    endtask

    task automatic test_one_shot();
        logic [31:0] v, e;
        do_reset();
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int k = 1; k <= 11; k++) begin
            exp_q.push_back((k >= 8) ? 32'd1 : 32'd0);
            exp_q.push_back((k >= 2 && k <= 7) ? 32'(7 - k) : 32'd0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({31'd0, irq} !== e) begin
                errors++;
                $display("FAIL oneshot_irq_e%0d: got %b expected %0d", k, irq, e);
            end
            rdreg(A_COUNT, v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL oneshot_count_e%0d: got %0d expected %0d", k, v, e);
            end
        end
        exp_q.push_back(32'h8);
        rdreg(A_CTRL, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            errors++;
            $display("FAIL oneshot_ctrl_en_clear: got %h expected %h", v, e);
        end
        exp_q.push_back(32'd0);
        wr(A_CTRL, 32'h8, 4'hF);
        e = exp_q.pop_front();
        checks++;
        if ({31'd0, irq} !== e) begin
            errors++;
            $display("FAIL oneshot_irq_clear: got %b expected %0d", irq, e);
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] v, e;
        int m;
        do_reset();
        wr(A_PRESET, 32'd3, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) begin
                exp_q.push_back(32'd0);
                exp_q.push_back(32'd0);
            end else begin
                m = (k - 2) % 6;
                exp_q.push_back((m == 4) ? 32'd1 : 32'd0);
                exp_q.push_back((m <= 3) ? 32'(3 - m) : 32'd0);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({31'd0, irq} !== e) begin
                errors++;
                $display("FAIL reload_irq_e%0d: got %b expected %0d", k, irq, e);
            end
            rdreg(A_COUNT, v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL reload_count_e%0d: got %0d expected %0d", k, v, e);
            end
        end
    endtask

    task automatic test_pause_preset();
        logic [31:0] v, e;
        bit found;
        do_reset();
        wr(A_PRESET, 32'd20, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            rdreg(A_COUNT, v);
            if (v == 32'd11) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL pause_reach11: got timeout expected count 11");
        end
        exp_q.push_back(32'd10);
        wr(A_CTRL, 32'h8, 4'hF);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd10);
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd9);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd7);
        for (int i = 0; i < 9; i++) begin
            if (i >= 1 && i <= 4) tick();
            else if (i == 5) wr(A_CTRL, 32'h9, 4'hF);
            else if (i == 6) tick();
            else if (i == 7) wr(A_PRESET, 32'd100, 4'hF);
            else if (i == 8) tick();
            rdreg(A_COUNT, v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL pause_count_step%0d: got %0d expected %0d", i, v, e);
            end
        end
    endtask

    task automatic test_preset_zero();
        logic [31:0] v, e;
        do_reset();
        wr(A_CTRL, 32'h9, 4'hF);
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back((k == 3) ? 32'd1 : 32'd0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({31'd0, irq} !== e) begin
                errors++;
                $display("FAIL zero_irq_e%0d: got %b expected %0d", k, irq, e);
            end
        end
        // EN rewrite lands on the same edge the expiry would drop it
        exp_q.push_back(32'h9);
        exp_q.push_back(32'd0);
        wr(A_CTRL, 32'h9, 4'hF);
        rdreg(A_CTRL, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            errors++;
            $display("FAIL zero_sw_en_wins: got %h expected %h", v, e);
        end
        e = exp_q.pop_front();
        checks++;
        if ({31'd0, irq} !== e) begin
            errors++;
            $display("FAIL zero_irq_ack: got %b expected %0d", irq, e);
        end
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back((k == 3) ? 32'd1 : 32'd0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({31'd0, irq} !== e) begin
                errors++;
                $display("FAIL zero_rearm_irq_%0d: got %b expected %0d", k, irq, e);
            end
        end
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h8);
        wr(A_CTRL, 32'h0, 4'h0);
        e = exp_q.pop_front();
        checks++;
        if ({31'd0, irq} !== e) begin
            errors++;
            $display("FAIL zero_be0_clear: got %b expected %0d", irq, e);
        end
        rdreg(A_CTRL, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            errors++;
            $display("FAIL zero_be0_ctrl: got %h expected %h", v, e);
        end
    endtask

    task automatic test_byte_lanes_mask();
        logic [31:0] v, e;
        do_reset();
        wr(A_PRESET, 32'hAABB_CCDD, 4'hF);
        wr(A_PRESET, 32'h0000_1100, 4'b0010);
        exp_q.push_back(32'hAABB_11DD);
        rdreg(A_PRESET, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            errors++;
            $display("FAIL lane_merge: got %h expected %h", v, e);
        end
        wr(A_PRESET, 32'hFFFF_FFFF, 4'h0);
        exp_q.push_back(32'hAABB_11DD);
        rdreg(A_PRESET, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            errors++;
            $display("FAIL lane_none: got %h expected %h", v, e);
        end
        wr(A_COUNT, 32'h1234, 4'hF);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        rdreg(A_COUNT, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            errors++;
            $display("FAIL count_ro: got %h expected %h", v, e);
        end
        rdreg(A_RSVD, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            errors++;
            $display("FAIL rsvd_read: got %h expected %h", v, e);
        end
        wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
        exp_q.push_back(32'h8);
        rdreg(A_CTRL, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            errors++;
            $display("FAIL ctrl_upper: got %h expected %h", v, e);
        end
        wr(A_PRESET, 32'd2, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(32'd0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({31'd0, irq} !== e) begin
                errors++;
                $display("FAIL masked_irq_e%0d: got %b expected %0d", k, irq, e);
            end
        end
        exp_q.push_back(32'd0);
        wr(A_CTRL, 32'h8, 4'hF);
        e = exp_q.pop_front();
        checks++;
        if ({31'd0, irq} !== e) begin
            errors++;
            $display("FAIL unmask_clears: got %b expected %0d", irq, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v, e;
        bit found;
        do_reset();
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            rdreg(A_COUNT, v);
            if (v == 32'd2) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach2: got timeout expected count 2");
        end
        reset = 1'b0;
        tick();
        for (int a = 0; a < 3; a++) begin
            exp_q.push_back(32'd0);
            rdreg(2'(a), v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL midreset_reg%0d: got %h expected %h", a, v, e);
            end
        end
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({31'd0, irq} !== e) begin
                errors++;
                $display("FAIL midreset_irq_%0d: got %b expected %0d", k, irq, e);
            end
            rdreg(A_COUNT, v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL midreset_count_%0d: got %0d expected %0d", k, v, e);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        be    = 4'h0;
        wd    = 32'd0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause_preset();
        test_preset_zero();
        test_byte_lanes_mask();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
